// File: rtl/interval_seq_pkg.sv
// Shared definitions for the interval sequencer slice.
//   seq_state_t     : sequencer FSM state encoding (2 bits)
//   DEF_WIDTH       : default interval / trigger width
//   DEF_NUM_SLOTS   : default number of interval slots
package interval_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_NUM_SLOTS = 4;

endpackage

// File: rtl/interval_slot_table.sv
// Register file holding the interval length of each slot.
//   clk, rst : clock, asynchronous active-high reset (clears every slot)
//   we       : write enable
//   waddr    : slot written
//   wdata    : interval value written
//   raddr    : slot read
//   rdata    : combinational read of slot raddr
module interval_slot_table #(
  parameter int WIDTH     = 16,
  parameter int NUM_SLOTS = 4,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [NUM_SLOTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/interval_sequencer.sv
// Steps an external up counter through a table of interval lengths,
// one interval per slot, either once or repeating.
//   clk, rst        : clock, asynchronous active-high reset
//   cfg_we/addr/data: slot table write port (ignored while busy)
//   cfg_last        : index of the last slot, latched at start
//   cfg_repeat      : wrap to slot 0 after the last slot, latched at start
//   start, stop     : begin sequence (IDLE only) / abort (any state)
//   cnt_rst, cnt_en, cnt_trigger : drive the counter
//   cnt_pulse       : counter terminal-count pulse
//   busy            : sequencer not idle
//   slot_idx        : active slot
//   slot_done       : registered one-cycle flag, a slot completed
//   seq_done        : registered one-cycle flag, the sequence completed
module interval_sequencer
  import interval_seq_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [IDX_W-1:0] cfg_last,
  input  logic             cfg_repeat,
  input  logic             start,
  input  logic             stop,
  output logic             cnt_rst,
  output logic             cnt_en,
  output logic [WIDTH-1:0] cnt_trigger,
  input  logic             cnt_pulse,
  output logic             busy,
  output logic [IDX_W-1:0] slot_idx,
  output logic             slot_done,
  output logic             seq_done
);

  seq_state_t       state, state_nxt;
  logic [IDX_W-1:0] slot_idx_nxt;
  logic [IDX_W-1:0] last_q, last_nxt;
  logic             rpt_q, rpt_nxt;
  logic             slot_done_nxt, seq_done_nxt;
  logic             table_we;

  // The table is frozen while a sequence runs.
  assign table_we = cfg_we && (state == IDLE);

  interval_slot_table #(
    .WIDTH    (WIDTH),
    .NUM_SLOTS(NUM_SLOTS),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk  (clk),
    .rst  (rst),
    .we   (table_we),
    .waddr(cfg_addr),
    .wdata(cfg_data),
    .raddr(slot_idx),
    .rdata(cnt_trigger)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      slot_idx  <= '0;
      last_q    <= '0;
      rpt_q     <= 1'b0;
      slot_done <= 1'b0;
      seq_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot_idx  <= slot_idx_nxt;
      last_q    <= last_nxt;
      rpt_q     <= rpt_nxt;
      slot_done <= slot_done_nxt;
      seq_done  <= seq_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    slot_idx_nxt  = slot_idx;
    last_nxt      = last_q;
    rpt_nxt       = rpt_q;
    slot_done_nxt = 1'b0;
    seq_done_nxt  = 1'b0;
    cnt_rst       = 1'b1;
    cnt_en        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          last_nxt     = cfg_last;
          rpt_nxt      = cfg_repeat;
          slot_idx_nxt = '0;
          state_nxt    = ARM;
        end
      end
      // Holding the counter in reset for one cycle guarantees count=0
      // when RUN begins, whatever the counter held before.
      ARM: state_nxt = RUN;
      RUN: begin
        cnt_rst = 1'b0;
        cnt_en  = 1'b1;
        // The counter self-clears on the pulse edge, and cnt_trigger
        // follows slot_idx on that same edge, so slots run back to back.
        if (cnt_pulse) begin
          slot_done_nxt = 1'b1;
          if (slot_idx != last_q) begin
            slot_idx_nxt = slot_idx + 1'b1;
          end else if (rpt_q) begin
            slot_idx_nxt = '0;
          end else begin
            state_nxt    = DONE;
            seq_done_nxt = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Abort overrides every transition and suppresses both flags.
    if (stop) begin
      state_nxt     = IDLE;
      slot_idx_nxt  = '0;
      slot_done_nxt = 1'b0;
      seq_done_nxt  = 1'b0;
    end
  end

endmodule

// File: doc/interval_sequencer.md
Name: interval_sequencer

Overview:
Controller for the team's general-purpose up counter (`counter` module: en, rst, trigger_count in; pulse out). Holds a small table of interval lengths and steps the counter through them in order, one interval per slot. Runs either once or repeating. Flags each completed slot and the end of the sequence. Sits between the CPU/config-register side and one counter instance in timer/waveform datapaths.

Parameters:
WIDTH, 16, width of interval values and of cnt_trigger; matches the counter's trigger_count.
NUM_SLOTS, 4, number of interval slots; power of two, at least 2.
IDX_W, $clog2(NUM_SLOTS), slot index width; derived, never overridden.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
cfg_we  input  1  write slot table; ignored while busy=1
cfg_addr  input  IDX_W  slot written
cfg_data  input  WIDTH  interval value
cfg_last  input  IDX_W  index of the last slot in the sequence; sampled at start
cfg_repeat  input  1  1 = wrap to slot 0 after the last slot; sampled at start
start  input  1  begin sequence; honoured only in IDLE
stop  input  1  abort; honoured in any state
cnt_rst  output  1  to counter rst
cnt_en  output  1  to counter en
cnt_trigger  output  WIDTH  to counter trigger_count
cnt_pulse  input  1  from counter pulse
busy  output  1  state != IDLE
slot_idx  output  IDX_W  active slot
slot_done  output  1  one-cycle flag: a slot completed, registered
seq_done  output  1  one-cycle flag: the sequence completed (non-repeat), registered

Behaviour:
- Reset (async) values: state=IDLE; slot table all 0; latched last=0 and repeat=0; slot_idx=0; slot_done=0; seq_done=0. Combinational outputs during reset: cnt_rst=1, cnt_en=0, busy=0.
- cnt_trigger = table[slot_idx]. It is driven combinationally from registers.
- States:
  - IDLE: cnt_rst=1, cnt_en=0. When start=1 and stop=0: latch cfg_last and cfg_repeat, set slot_idx=0, go to ARM.
  - ARM (one cycle): cnt_rst=1, cnt_en=0, which guarantees count=0. Next state is RUN.
  - RUN: cnt_rst=0, cnt_en=1. On each cycle with cnt_pulse=1:
    - slot_done=1 on the next cycle.
    - If slot_idx != last: slot_idx+1.
    - Else if repeat: slot_idx=0, stay in RUN.
    - Else: go to DONE, slot_idx unchanged.
  - DONE (one cycle): cnt_rst=1, cnt_en=0. seq_done=1 during this cycle. Next state is IDLE.
- Timing per slot:
  - A slot holding value V lasts V+1 RUN cycles.
  - V=0 lasts exactly 1 cycle.
  - The counter self-clears on pulse and cnt_trigger switches on the same edge, so there are no dead cycles between slots.
- Latency: start sampled at edge E. Then ARM runs from E to E+1, RUN begins at E+1, and the first pulse falls in cycle E+1+V0.
- stop=1 at any edge: next state is IDLE, slot_idx=0, no slot_done and no seq_done. stop has priority over start, cnt_pulse and every state transition.
- start while busy: ignored.
- cfg_we while busy: ignored, table unchanged. cfg_we in IDLE in the same cycle as start: the write takes effect, and the new value is used if that slot is slot 0.
- cfg_last is latched at start. Later changes have no effect on a running sequence.
- slot_done and seq_done are never asserted in IDLE or ARM.

Decomposition:
- Shared package interval_seq_pkg holds:
  - the state enum (IDLE, ARM, RUN, DONE), 2 bits;
  - the default WIDTH and NUM_SLOTS localparams.
- One natural sub-module, interval_slot_table:
  - NUM_SLOTS x WIDTH register file;
  - async reset to 0, write port gated by a write enable, combinational read by index.
- The FSM and index logic live in interval_sequencer. The counter is instantiated by the parent, not inside this block.

Test Plan:
1. Bench setup: counter instance connected. Write slots {3,1,0,5}, last=3, repeat=0, start at edge E -> pulses in cycles E+4, E+6, E+7, E+13. slot_done in E+5, E+7, E+8, E+14. slot_idx steps 0,1,2,3. seq_done in E+14. busy falls at E+15.
2. Same table with repeat=1, last=1 -> pulses every 4 then 2 cycles indefinitely (E+4, E+6, E+10, E+12, ...). slot_idx alternates 0,1. seq_done is never asserted.
3. stop asserted in RUN mid-slot 2 -> next cycle IDLE, cnt_rst=1, slot_idx=0, no slot_done or seq_done. Restart -> the counter starts again from count 0, and the first slot again takes V0+1 cycles.
4. cfg_we to slot 0 with value 9 while busy -> table unchanged, readback after done shows the old value. The same write in IDLE, then start -> the first pulse arrives at E+10.
5. start and stop in the same IDLE cycle -> stays in IDLE, busy=0. start asserted while in RUN -> no effect on slot_idx or timing.
6. Async reset asserted mid-RUN, off a clock edge -> immediately busy=0, cnt_rst=1, cnt_en=0. All slots read 0. After reset release, start with last=0 -> 1-cycle slot, seq_done at E+2.
